// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - command encoding shared by the SPI RAM slave
package spi_ram_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

endpackage

// File: rtl/spi_ram_burst_if.sv
// rtl/spi_ram_burst_if.sv - command/response bundle between SPI front end and RAM slave
interface spi_ram_burst_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              rx_valid;
  logic [DATA_W+1:0] din;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_wrap;
  logic              rd_wrap;

  modport master (
    output rx_valid, din,
    input  dout, tx_valid, wr_ptr, rd_ptr, wr_wrap, rd_wrap
  );

  modport slave (
    input  rx_valid, din,
    output dout, tx_valid, wr_ptr, rd_ptr, wr_wrap, rd_wrap
  );
endinterface

// File: rtl/spi_ram_mem.sv
// rtl/spi_ram_mem.sv - storage array with synchronous write and registered read
module spi_ram_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Array has no reset so it can map onto RAM macros.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/spi_ram_burst.sv
// rtl/spi_ram_burst.sv - RAM slave: command decode, auto-increment pointers, wrap flags
// and read-latency pipeline in front of spi_ram_mem.
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int AUTO_INC = 1,
  parameter int RD_LAT   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_ram_burst_if.slave  bus
);
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
    $error("spi_ram_burst: RD_LAT must be 1 or 2");
  end
  if (ADDR_W > DATA_W) begin : g_bad_addr_w
    $error("spi_ram_burst: ADDR_W must not exceed DATA_W");
  end

  cmd_t              cmd;
  logic [DATA_W-1:0] payload;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              wr_wrap_q, wr_wrap_d;
  logic              rd_wrap_q, rd_wrap_d;
  logic              we;
  logic              re;
  logic              rd_v1_q, rd_v1_d;
  logic [DATA_W-1:0] rdata;

  assign cmd     = cmd_t'(bus.din[DATA_W+1:DATA_W]);
  assign payload = bus.din[DATA_W-1:0];

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    wr_wrap_d = wr_wrap_q;
    rd_wrap_d = rd_wrap_q;
    we        = 1'b0;
    re        = 1'b0;
    if (bus.rx_valid) begin
      unique case (cmd)
        CMD_WR_ADDR: begin
          wr_ptr_d  = payload[ADDR_W-1:0];
          wr_wrap_d = 1'b0;
        end
        CMD_WR_DATA: begin
          we = 1'b1;
          if (AUTO_INC != 0) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (wr_ptr_q == {ADDR_W{1'b1}}) wr_wrap_d = 1'b1;
          end
        end
        CMD_RD_ADDR: begin
          rd_ptr_d  = payload[ADDR_W-1:0];
          rd_wrap_d = 1'b0;
        end
        CMD_RD_DATA: begin
          re = 1'b1;
          if (AUTO_INC != 0) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            if (rd_ptr_q == {ADDR_W{1'b1}}) rd_wrap_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_v1_d = re;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      wr_wrap_q <= 1'b0;
      rd_wrap_q <= 1'b0;
      rd_v1_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_wrap_q <= wr_wrap_d;
      rd_wrap_q <= rd_wrap_d;
      rd_v1_q   <= rd_v1_d;
    end
  end

  spi_ram_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (payload),
    .re    (re),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  // The memory read register is the first latency stage; RD_LAT=2 adds one more.
  if (RD_LAT == 2) begin : g_lat2
    logic              rd_v2_q, rd_v2_d;
    logic [DATA_W-1:0] dout2_q, dout2_d;

    always_comb begin
      rd_v2_d = rd_v1_q;
      dout2_d = dout2_q;
      if (rd_v1_q) dout2_d = rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_v2_q <= 1'b0;
        dout2_q <= '0;
      end else begin
        rd_v2_q <= rd_v2_d;
        dout2_q <= dout2_d;
      end
    end

    assign bus.tx_valid = rd_v2_q;
    assign bus.dout     = dout2_q;
  end else begin : g_lat1
    assign bus.tx_valid = rd_v1_q;
    assign bus.dout     = rdata;
  end

  assign bus.wr_ptr  = wr_ptr_q;
  assign bus.rd_ptr  = rd_ptr_q;
  assign bus.wr_wrap = wr_wrap_q;
  assign bus.rd_wrap = rd_wrap_q;
endmodule

// File: doc/spi_ram_burst.md
Name: spi_ram_burst

Overview:
- Parametrised single-port-style RAM slave behind the SPI slave front end.
- Decodes 2-bit command + payload words arriving with rx_valid; supports set-write-address, write-data, set-read-address, read-data.
- Successor to the fixed 256x8 RAM: generic width and depth, optional address auto-increment for burst transfers, configurable read latency, wrap flags.

Parameters:
- DATA_W, 8, data/payload width; din is DATA_W+2 bits.
- ADDR_W, 8, address width; must satisfy ADDR_W <= DATA_W; DEPTH = 2**ADDR_W.
- AUTO_INC, 1, 1 = pointer increments after each data write/read; 0 = pointer holds.
- RD_LAT, 1, read latency in cycles from read command to tx_valid; legal values 1 or 2.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- rx_valid  in  1  din qualifier, one word per cycle when high
- din  in  DATA_W+2  [DATA_W+1:DATA_W] = cmd, [DATA_W-1:0] = payload
- dout  out  DATA_W  read data, valid when tx_valid high
- tx_valid  out  1  one-cycle pulse per completed read
- wr_ptr  out  ADDR_W  current write pointer
- rd_ptr  out  ADDR_W  current read pointer
- wr_wrap  out  1  sticky: write pointer wrapped DEPTH-1 -> 0
- rd_wrap  out  1  sticky: read pointer wrapped DEPTH-1 -> 0

Behaviour:
- Reset (async, rst_n low): dout=0, tx_valid=0, wr_ptr=0, rd_ptr=0, wr_wrap=0, rd_wrap=0, read pipeline flushed. Memory contents are not cleared and are undefined after power-up.
- Commands are acted on only when rx_valid=1. With rx_valid=0, no state changes except read pipeline advance.
- cmd 00: wr_ptr <= payload[ADDR_W-1:0]; wr_wrap <= 0.
- cmd 01: mem[wr_ptr] <= payload. If AUTO_INC, wr_ptr <= wr_ptr+1 modulo DEPTH; on DEPTH-1 -> 0, wr_wrap <= 1.
- cmd 10: rd_ptr <= payload[ADDR_W-1:0]; rd_wrap <= 0.
- cmd 11: issue read of mem[rd_ptr]; payload ignored. If AUTO_INC, rd_ptr increments modulo DEPTH with wrap flag as for writes.
- Read latency:
  - RD_LAT=1: dout = mem[rd_ptr] and tx_valid=1 on the edge after the command cycle.
  - RD_LAT=2: one extra register stage.
  - Reads are fully pipelined; back-to-back cmd 11 on consecutive cycles gives consecutive tx_valid pulses in issue order.
- tx_valid is high for exactly one cycle per read command, otherwise 0. dout holds its last value when tx_valid=0.
- Read/write collision: a write and a read issued for the same address cannot fall in the same cycle because there is a single command per cycle. A read issued the cycle after a write to that address returns the new data.
- Pointers are independent; a write never moves rd_ptr, and a read never moves wr_ptr.
- Reset asserted mid-pipeline: the pending read is dropped, with no tx_valid after reset release.
- Illegal RD_LAT value: elaboration-time error via generate check.

Decomposition:
- Shared package spi_ram_pkg: cmd encoding constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11; cmd_t enum.
- One natural sub-module: spi_ram_mem (storage array, synchronous write, registered read, no reset on the array); the top holds decode, pointers, wrap flags and latency pipeline.

Test Plan:
- Reset mid-read, RD_LAT=2: cmd 11 issued, then rst_n low for 1 cycle -> no tx_valid pulse; dout=0, pointers 0.
- Basic write/read: 00/0x10, 01/0xA5, 10/0x10, 11 -> one cycle later dout=0xA5, tx_valid=1 for 1 cycle; wr_ptr=0x11, rd_ptr=0x11.
- Burst, AUTO_INC=1: write 0x01..0x04 from addr 0x20, then set rd 0x20 and issue four back-to-back 11 -> dout sequence 01,02,03,04 on four consecutive tx_valid cycles.
- Wrap: set wr 0xFF, write 0x11, 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22, wr_wrap=1; then cmd 00 -> wr_wrap=0.
- AUTO_INC=0: two writes 0x33, 0x44 at addr 0x05 -> mem[0x05]=0x44, wr_ptr stays 0x05.
- rx_valid gating: cmd 11 with rx_valid=0 -> no tx_valid, rd_ptr unchanged.
